logic_axi4_stream_demux_router: RTL and testbench

LOGIC_AXI4_STREAM_DEMUX_ROUTER -- requirements
Module: logic_axi4_stream_demux_router

---
 rtl/logic_axi4_stream_demux_router.sv | 212 +++++++++++++++++++++
 tb/tb_logic_axi4_stream_demux_router.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_axi4_stream_demux_router.sv
`timescale 1ns/1ps
// logic_axi4_stream_demux_router
//   Routes AXI4-Stream packets from one Rx port to one of N Tx ports by
//   decoding tdest on the first beat of each packet. Unmapped packets are
//   dropped (UNMAPPED_MODE=0) or routed to the extra port OUTPUTS
//   (UNMAPPED_MODE=1). Every Tx port has a 2-entry registered skid buffer.
// Ports
//   aclk, areset           : clock, asynchronous active-high reset
//   rx_*                   : AXI4-Stream slave (tvalid/tready/tdata/tkeep/tdest/tuser/tlast)
//   tx_*                   : N packed AXI4-Stream masters, N = OUTPUTS + UNMAPPED_MODE
//   drop_count             : saturating count of dropped packets
// MAP holds entry i at bits [i*TDEST_WIDTH +: TDEST_WIDTH]; the default maps entry i to tdest i.

package logic_axi4_stream_demux_router_pkg;
    function automatic logic [511:0] default_map(input int unsigned n, input int unsigned w);
        logic [511:0] m;
        logic [31:0]  v;
        m = '0;
        for (int unsigned i = 0; i < n && i < 16; i++) begin
            v = i;
            for (int unsigned b = 0; b < w && b < 32; b++) begin
                if (i * w + b < 512) m[9'(i * w + b)] = v[5'(b)];
            end
        end
        return m;
    endfunction
endpackage

module logic_axi4_stream_demux_router
    import logic_axi4_stream_demux_router_pkg::*;
#(
    parameter int unsigned  OUTPUTS          = 4,
    parameter int unsigned  TDATA_BYTES      = 4,
    parameter int unsigned  TDEST_WIDTH      = 4,
    parameter int unsigned  TUSER_WIDTH      = 1,
    parameter int unsigned  UNMAPPED_MODE    = 0,
    parameter logic [511:0] MAP              = default_map(OUTPUTS, TDEST_WIDTH),
    parameter int unsigned  DROP_COUNT_WIDTH = 16,
    localparam int unsigned N                = OUTPUTS + UNMAPPED_MODE
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          rx_tvalid,
    output logic                          rx_tready,
    input  logic [8*TDATA_BYTES-1:0]      rx_tdata,
    input  logic [TDATA_BYTES-1:0]        rx_tkeep,
    input  logic [TDEST_WIDTH-1:0]        rx_tdest,
    input  logic [TUSER_WIDTH-1:0]        rx_tuser,
    input  logic                          rx_tlast,
    output logic [N-1:0]                  tx_tvalid,
    input  logic [N-1:0]                  tx_tready,
    output logic [N*8*TDATA_BYTES-1:0]    tx_tdata,
    output logic [N*TDATA_BYTES-1:0]      tx_tkeep,
    output logic [N*TDEST_WIDTH-1:0]      tx_tdest,
    output logic [N*TUSER_WIDTH-1:0]      tx_tuser,
    output logic [N-1:0]                  tx_tlast,
    output logic [DROP_COUNT_WIDTH-1:0]   drop_count
);

    localparam int unsigned DW = 8 * TDATA_BYTES;
    localparam int unsigned PW = DW + TDATA_BYTES + TDEST_WIDTH + TUSER_WIDTH + 1;
    localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

    state_t                        state_q, state_d;
    logic [SW-1:0]                 sel_q, sel_d;
    logic                          ready_en_q;
    logic [DROP_COUNT_WIDTH-1:0]   drop_q, drop_d;
    logic [PW-1:0]                 head_q [N];
    logic [PW-1:0]                 head_d [N];
    logic [PW-1:0]                 tail_q [N];
    logic [PW-1:0]                 tail_d [N];
    logic [1:0]                    cnt_q  [N];
    logic [1:0]                    cnt_d  [N];

    logic [OUTPUTS-1:0]            map_hit;
    logic                          dec_hit;
    logic [SW-1:0]                 dec_idx;
    logic [SW-1:0]                 cur_sel;
    logic                          first_drop;
    logic                          dropping;
    logic                          full_sel;
    logic                          accept;
    logic [PW-1:0]                 rx_payload;

    assign rx_payload = {rx_tdata, rx_tkeep, rx_tdest, rx_tuser, rx_tlast};

    for (genvar g = 0; g < OUTPUTS; g++) begin : g_map
        assign map_hit[g] = (MAP[g*TDEST_WIDTH +: TDEST_WIDTH] == rx_tdest);
    end

    // Lowest matching MAP index wins.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int unsigned i = 0; i < OUTPUTS; i++) begin
            if (!dec_hit && map_hit[i]) begin
                dec_hit = 1'b1;
                dec_idx = SW'(i);
            end
        end
    end

    // rx_tready depends on state, buffer occupancy and rx_tdest only, never rx_tvalid.
    always_comb begin
        first_drop = (state_q == IDLE) && !dec_hit && (UNMAPPED_MODE == 0);
        cur_sel    = (state_q == IDLE) ? (dec_hit ? dec_idx : SW'(OUTPUTS)) : sel_q;
        dropping   = first_drop || (state_q == DROP);
        full_sel   = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (cur_sel == SW'(i) && cnt_q[i] == 2'd2) full_sel = 1'b1;
        end
        rx_tready = ready_en_q && (dropping || !full_sel);
        accept    = rx_tvalid && rx_tready;
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        drop_d  = drop_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (first_drop && drop_q != '1) drop_d = drop_q + DROP_COUNT_WIDTH'(1);
                    if (!rx_tlast) begin
                        if (first_drop) begin
                            state_d = DROP;
                        end else begin
                            state_d = ROUTE;
                            sel_d   = cur_sel;
                        end
                    end
                end
            end
            ROUTE, DROP: begin
                if (accept && rx_tlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Skid buffers: head drives the port, tail only fills while head is stalled.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            logic push, pop;
            head_d[i] = head_q[i];
            tail_d[i] = tail_q[i];
            cnt_d[i]  = cnt_q[i];
            push = accept && !dropping && (cur_sel == SW'(i));
            pop  = (cnt_q[i] != 2'd0) && tx_tready[i];
            case (cnt_q[i])
                2'd0: begin
                    if (push) begin
                        head_d[i] = rx_payload;
                        cnt_d[i]  = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_d[i] = rx_payload;
                    end else if (push) begin
                        tail_d[i] = rx_payload;
                        cnt_d[i]  = 2'd2;
                    end else if (pop) begin
                        cnt_d[i] = 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head_d[i] = tail_q[i];
                        cnt_d[i]  = 2'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            ready_en_q <= 1'b0;
            drop_q     <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                head_q[i] <= '0;
                tail_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            ready_en_q <= 1'b1;
            drop_q     <= drop_d;
            for (int unsigned i = 0; i < N; i++) begin
                head_q[i] <= head_d[i];
                tail_q[i] <= tail_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_tx
        assign tx_tvalid[g] = (cnt_q[g] != 2'd0);
        assign {tx_tdata[g*DW +: DW], tx_tkeep[g*TDATA_BYTES +: TDATA_BYTES],
                tx_tdest[g*TDEST_WIDTH +: TDEST_WIDTH], tx_tuser[g*TUSER_WIDTH +: TUSER_WIDTH],
                tx_tlast[g]} = head_q[g];
    end

    assign drop_count = drop_q;

endmodule

// File: tb/tb_logic_axi4_stream_demux_router.sv
`timescale 1ns/1ps
// Bench for logic_axi4_stream_demux_router: a queue-based packet model of the
// default 4-output drop-mode instance, plus a second instance in mode 1.
module tb_logic_axi4_stream_demux_router;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;
    logic areset = 1'b0;

    // Instance 0: OUTPUTS=4, UNMAPPED_MODE=0
    logic         rx_tvalid = 1'b0;
    logic         rx_tready;
    logic [31:0]  rx_tdata  = '0;
    logic [3:0]   rx_tkeep  = '0;
    logic [3:0]   rx_tdest  = '0;
    logic [0:0]   rx_tuser  = '0;
    logic         rx_tlast  = 1'b0;
    logic [3:0]   tx_tvalid;
    logic [3:0]   tx_tready = 4'hF;
    logic [127:0] tx_tdata;
    logic [15:0]  tx_tkeep;
    logic [15:0]  tx_tdest;
    logic [3:0]   tx_tuser;
    logic [3:0]   tx_tlast;
    logic [15:0]  drop_count;

    // Instance 1: OUTPUTS=4, UNMAPPED_MODE=1
    logic         rx1_tvalid = 1'b0;
    logic         rx1_tready;
    logic [31:0]  rx1_tdata  = '0;
    logic [3:0]   rx1_tkeep  = '0;
    logic [3:0]   rx1_tdest  = '0;
    logic [0:0]   rx1_tuser  = '0;
    logic         rx1_tlast  = 1'b0;
    logic [4:0]   tx1_tvalid;
    logic [4:0]   tx1_tready = 5'h1F;
    logic [159:0] tx1_tdata;
    logic [19:0]  tx1_tkeep;
    logic [19:0]  tx1_tdest;
    logic [4:0]   tx1_tuser;
    logic [4:0]   tx1_tlast;
    logic [15:0]  drop1_count;

    logic_axi4_stream_demux_router #(
        .OUTPUTS(4), .TDATA_BYTES(4), .TDEST_WIDTH(4), .TUSER_WIDTH(1),
        .UNMAPPED_MODE(0), .DROP_COUNT_WIDTH(16)
    ) u_dut0 (
        .aclk(aclk), .areset(areset),
        .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tdata(rx_tdata),
        .rx_tkeep(rx_tkeep), .rx_tdest(rx_tdest), .rx_tuser(rx_tuser), .rx_tlast(rx_tlast),
        .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tdata(tx_tdata),
        .tx_tkeep(tx_tkeep), .tx_tdest(tx_tdest), .tx_tuser(tx_tuser), .tx_tlast(tx_tlast),
        .drop_count(drop_count)
    );

    logic_axi4_stream_demux_router #(
        .OUTPUTS(4), .TDATA_BYTES(4), .TDEST_WIDTH(4), .TUSER_WIDTH(1),
        .UNMAPPED_MODE(1), .DROP_COUNT_WIDTH(16)
    ) u_dut1 (
        .aclk(aclk), .areset(areset),
        .rx_tvalid(rx1_tvalid), .rx_tready(rx1_tready), .rx_tdata(rx1_tdata),
        .rx_tkeep(rx1_tkeep), .rx_tdest(rx1_tdest), .rx_tuser(rx1_tuser), .rx_tlast(rx1_tlast),
        .tx_tvalid(tx1_tvalid), .tx_tready(tx1_tready), .tx_tdata(tx1_tdata),
        .tx_tkeep(tx1_tkeep), .tx_tdest(tx1_tdest), .tx_tuser(tx1_tuser), .tx_tlast(tx1_tlast),
        .drop_count(drop1_count)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet model: each queue holds the beats accepted for a port but not yet taken.
    logic [41:0] mq [4][$];
    bit          m_in_pkt   = 1'b0;
    bit          m_drop     = 1'b0;
    int          m_dest     = 0;
    bit          m_ready_en = 1'b0;
    int          m_drops    = 0;

    function automatic logic [41:0] rx_pl();
        return {rx_tdata, rx_tkeep, rx_tdest, rx_tuser, rx_tlast};
    endfunction

    function automatic logic [41:0] act_pl(input int o);
        return {tx_tdata[o*32 +: 32], tx_tkeep[o*4 +: 4], tx_tdest[o*4 +: 4], tx_tuser[o], tx_tlast[o]};
    endfunction

    // Default MAP sends tdest 0..3 to the port of the same number.
    function automatic bit exp_ready();
        if (!m_ready_en) return 1'b0;
        if (m_in_pkt) return m_drop ? 1'b1 : (mq[m_dest].size() < 2);
        if (rx_tdest < 4) return mq[rx_tdest].size() < 2;
        return 1'b1;
    endfunction

    always @(posedge aclk or posedge areset) begin : model
        bit rdy;
        int d;
        if (areset) begin
            for (int o = 0; o < 4; o++) mq[o].delete();
            m_in_pkt   = 1'b0;
            m_drop     = 1'b0;
            m_dest     = 0;
            m_ready_en = 1'b0;
            m_drops    = 0;
        end else begin
            rdy = exp_ready();
            for (int o = 0; o < 4; o++) begin
                if (mq[o].size() != 0 && tx_tready[o]) void'(mq[o].pop_front());
            end
            if (rdy && rx_tvalid) begin
                if (!m_in_pkt) begin
                    if (rx_tdest < 4) begin
                        d = int'(rx_tdest);
                        mq[d].push_back(rx_pl());
                        m_drop = 1'b0;
                        m_dest = d;
                    end else begin
                        m_drop = 1'b1;
                        if (m_drops < 65535) m_drops++;
                    end
                    m_in_pkt = !rx_tlast;
                end else begin
                    if (!m_drop) mq[m_dest].push_back(rx_pl());
                    if (rx_tlast) m_in_pkt = 1'b0;
                end
            end
            m_ready_en = 1'b1;
        end
    end

    always @(negedge aclk) begin : compare
        logic [3:0] ev;
        if (chk_en) begin
            chk("rx_tready", 64'(rx_tready), 64'(exp_ready()));
            for (int o = 0; o < 4; o++) ev[o] = (mq[o].size() != 0);
            chk("tx_tvalid", 64'(tx_tvalid), 64'(ev));
            chk("drop_count", 64'(drop_count), 64'(m_drops));
            for (int o = 0; o < 4; o++) begin
                if (ev[o]) chk("tx_payload", 64'(act_pl(o)), 64'(mq[o][0]));
            end
            if (areset) chk("reset_tdata_zero", 64'(|tx_tdata), 64'd0);
        end
    end

    task automatic send(input logic [3:0] d, input logic [31:0] data, input logic last);
        int w;
        rx_tvalid = 1'b1;
        rx_tdest  = d;
        rx_tdata  = data;
        rx_tkeep  = data[7:4];
        rx_tuser  = data[0];
        rx_tlast  = last;
        w = 0;
        @(negedge aclk);
        while (!rx_tready && w < 200) begin
            w++;
            @(negedge aclk);
        end
        chk("send_accept", 64'(rx_tready), 64'd1);
        @(posedge aclk);
        #1;
    endtask

    task automatic send1(input logic [3:0] d, input logic [31:0] data, input logic last);
        int w;
        rx1_tvalid = 1'b1;
        rx1_tdest  = d;
        rx1_tdata  = data;
        rx1_tkeep  = data[7:4];
        rx1_tuser  = data[0];
        rx1_tlast  = last;
        w = 0;
        @(negedge aclk);
        while (!rx1_tready && w < 200) begin
            w++;
            @(negedge aclk);
        end
        chk("send1_accept", 64'(rx1_tready), 64'd1);
        @(posedge aclk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        #2;
        areset = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_rx_tready", 64'(rx_tready), 64'd0);
        chk("rst_tx_tvalid", 64'(tx_tvalid), 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);
        areset = 1'b0;
        @(posedge aclk);
        #1;

        // 3-beat packet to tdest 2
        tx_tready = 4'hF;
        send(4'd2, 32'hA1A1_00A1, 1'b0);
        chk("p030_valid1", 64'(tx_tvalid), 64'h4);
        chk("p030_data1", 64'(tx_tdata[95:64]), 64'hA1A1_00A1);
        send(4'd2, 32'hA2A2_00A2, 1'b0);
        chk("p030_data2", 64'(tx_tdata[95:64]), 64'hA2A2_00A2);
        send(4'd2, 32'hA3A3_00A3, 1'b1);
        rx_tvalid = 1'b0;
        chk("p030_last3", 64'(tx_tlast), 64'h4);
        chk("p030_data3", 64'(tx_tdata[95:64]), 64'hA3A3_00A3);
        repeat (2) @(posedge aclk);
        #1;

        // Two 4-beat packets to unmapped tdest 9
        for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < 4; b++) send(4'd9, 32'h9000_0000 + 32'(p * 16 + b), 1'(b == 3));
        end
        rx_tvalid = 1'b0;
        #1;
        chk("p031_drops", 64'(drop_count), 64'd2);
        chk("p031_no_valid", 64'(tx_tvalid), 64'd0);

        // Fill port 0, then stall port 1 during a 5-beat packet
        tx_tready = 4'h0;
        send(4'd0, 32'hB1B1_00B1, 1'b0);
        send(4'd0, 32'hB2B2_00B2, 1'b1);
        rx_tvalid = 1'b0;
        chk("p033_pre", 64'(tx_tvalid), 64'h1);
        tx_tready = 4'b1101;
        fork
            begin
                for (int b = 0; b < 5; b++) send(4'd1, 32'hC000_00C0 + 32'(b), 1'(b == 4));
                rx_tvalid = 1'b0;
            end
            begin
                repeat (10) @(posedge aclk);
                #1;
                chk("p033_blocked", 64'(rx_tready), 64'd0);
                chk("p033_tx0_drained", 64'(tx_tvalid), 64'h2);
                tx_tready = 4'hF;
            end
        join
        repeat (4) @(posedge aclk);
        #1;

        // tdest changes mid-packet
        send(4'd0, 32'hD1D1_00D1, 1'b0);
        send(4'd3, 32'hD2D2_00D2, 1'b0);
        chk("p034_valid2", 64'(tx_tvalid), 64'h1);
        send(4'd3, 32'hD3D3_00D3, 1'b1);
        rx_tvalid = 1'b0;
        chk("p034_last_on_tx0", 64'(tx_tlast[0]), 64'd1);
        repeat (2) @(posedge aclk);
        #1;

        // Reset mid-packet with beats buffered on port 2
        tx_tready = 4'b1011;
        send(4'd2, 32'hF1F1_00F1, 1'b0);
        send(4'd2, 32'hF2F2_00F2, 1'b0);
        rx_tvalid = 1'b0;
        chk("p035_buffered", 64'(tx_tvalid), 64'h4);
        areset = 1'b1;
        #1;
        chk("p035_rst_valid", 64'(tx_tvalid), 64'd0);
        chk("p035_rst_ready", 64'(rx_tready), 64'd0);
        chk("p035_rst_data", 64'(|tx_tdata), 64'd0);
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        #1;
        chk("p035_ready_after_release", 64'(rx_tready), 64'd0);
        tx_tready = 4'hF;
        @(posedge aclk);
        #1;
        send(4'd1, 32'hE1E1_00E1, 1'b0);
        chk("p035_valid1", 64'(tx_tvalid), 64'h2);
        chk("p035_data1", 64'(tx_tdata[63:32]), 64'hE1E1_00E1);
        send(4'd1, 32'hE2E2_00E2, 1'b0);
        send(4'd1, 32'hE3E3_00E3, 1'b1);
        rx_tvalid = 1'b0;
        repeat (3) @(posedge aclk);
        #1;

        // Mode 1: unmapped tdest 9 goes to port 4
        send1(4'd9, 32'h5151_0051, 1'b0);
        chk("p032_valid1", 64'(tx1_tvalid), 64'h10);
        chk("p032_data1", 64'(tx1_tdata[159:128]), 64'h5151_0051);
        chk("p032_dest1", 64'(tx1_tdest[19:16]), 64'd9);
        send1(4'd9, 32'h5252_0052, 1'b0);
        chk("p032_data2", 64'(tx1_tdata[159:128]), 64'h5252_0052);
        send1(4'd9, 32'h5353_0053, 1'b1);
        rx1_tvalid = 1'b0;
        chk("p032_last3", 64'(tx1_tlast), 64'h10);
        chk("p032_keep3", 64'(tx1_tkeep[19:16]), 64'h5);
        @(posedge aclk);
        #1;
        chk("p032_drained", 64'(tx1_tvalid), 64'd0);
        chk("p032_no_drops", 64'(drop1_count), 64'd0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
